// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter unit: jump-field encoding
// and the default reset/trap vectors.
package pc_sequencer_pkg;

  // Encoding of the 2-bit jump selector driven by the controller.
  typedef enum logic [1:0] {
    JMP_SEQ  = 2'd0,  // sequential or branch
    JMP_PAGE = 2'd1,  // page-absolute: upper PC bits kept, low bits from ins
    JMP_RM   = 2'd2,  // register-indirect through rm
    JMP_RD   = 2'd3   // register-indirect through rd
  } jump_e;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_TRAP_VEC  = 16'h0004;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry. Push+pop together replaces the top entry, or acts as a
// plain push when the stack is empty. A pop from an empty stack leaves the
// pointer alone and raises a one-cycle underflow pulse.
module pc_ras #(
  parameter int XLEN      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            uflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] ONE_P   = PW'(1'b1);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   sp_r;       // next free slot; wraps naturally (power-of-two depth)
  logic [PW-1:0]   sp_s;
  logic [PW-1:0]   wr_idx_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_s;
  logic            wr_en_s;
  logic            uflow_s;
  logic            is_empty_s;

  assign is_empty_s = (count_r == ZERO_C);
  assign top        = mem[sp_r - ONE_P];

  // Next pointer/count, write slot and underflow detection for this commit.
  always_comb begin
    sp_s     = sp_r;
    count_s  = count_r;
    wr_en_s  = 1'b0;
    wr_idx_s = sp_r;
    uflow_s  = 1'b0;
    if (en && push && pop) begin
      wr_en_s = 1'b1;
      if (is_empty_s) begin
        sp_s    = sp_r + ONE_P;
        count_s = count_r + ONE_C;
        uflow_s = 1'b1;
      end else begin
        wr_idx_s = sp_r - ONE_P;
      end
    end else if (en && push) begin
      wr_en_s = 1'b1;
      sp_s    = sp_r + ONE_P;
      if (count_r == DEPTH_C) begin
        count_s = count_r;
      end else begin
        count_s = count_r + ONE_C;
      end
    end else if (en && pop) begin
      if (is_empty_s) begin
        uflow_s = 1'b1;
      end else begin
        sp_s    = sp_r - ONE_P;
        count_s = count_r - ONE_C;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Pointer, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r    <= {PW{1'b0}};
      count_r <= ZERO_C;
      empty   <= 1'b1;
      full    <= 1'b0;
      uflow   <= 1'b0;
    end else begin
      sp_r    <= sp_s;
      count_r <= count_s;
      empty   <= (count_s == ZERO_C);
      full    <= (count_s == DEPTH_C);
      uflow   <= uflow_s;
    end
  end

  // Entry storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns pc/epc, selects the next PC from the control
// inputs and drives the return-address stack for call/return.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN      = 16,
  parameter int              BOFF_W    = 8,
  parameter int              JIMM_W    = 11,   // BOFF_W <= JIMM_W < XLEN
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [JIMM_W-1:0] ins,
  input  logic              branch,
  input  logic [1:0]        jump,
  input  logic              call,
  input  logic              ret,
  input  logic              trap,
  input  logic [XLEN-1:0]   rm,
  input  logic [XLEN-1:0]   rd,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus1,
  output logic [XLEN-1:0]   next_pc,
  output logic [XLEN-1:0]   epc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_uflow
);

  logic [XLEN-1:0] ras_top_s;
  logic [XLEN-1:0] boff_s;
  logic [XLEN-1:0] page_tgt_s;
  logic            ras_push_s;
  logic            ras_pop_s;

  assign pc_plus1   = pc + {{(XLEN-1){1'b0}}, 1'b1};
  assign boff_s     = {{(XLEN-BOFF_W){ins[BOFF_W-1]}}, ins[BOFF_W-1:0]};
  assign page_tgt_s = {pc[XLEN-1:JIMM_W], ins};

  // A trap suppresses any stack activity requested in the same commit.
  assign ras_push_s = call && !trap;
  assign ras_pop_s  = ret && !trap;

  // Target selection: trap > ret > jump > branch > sequential.
  always_comb begin
    next_pc = pc_plus1;
    if (trap) begin
      next_pc = TRAP_VEC;
    end else if (ret) begin
      if (ras_empty) begin
        next_pc = rm;
      end else begin
        next_pc = ras_top_s;
      end
    end else begin
      case (jump)
        JMP_PAGE: next_pc = page_tgt_s;
        JMP_RM:   next_pc = rm;
        JMP_RD:   next_pc = rd;
        JMP_SEQ:  next_pc = branch ? (pc + boff_s) : pc_plus1;
        default:  next_pc = pc_plus1;
      endcase
    end
  end

  // Architectural PC and exception PC commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_VEC;
      epc <= {XLEN{1'b0}};
    end else if (pc_en) begin
      pc <= next_pc;
      if (trap) begin
        epc <= pc;
      end
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .en        (pc_en),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_plus1),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full),
    .uflow     (ras_uflow)
  );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the multicycle RISC core. Owns the architectural PC register, computes the next PC (sequential, branch, page-absolute jump, register-indirect jump, trap, return), and keeps a hardware return-address stack (RAS) for call/return. It sits between the multicycle controller, which issues `pc_en` once per instruction, and the instruction memory address port.

## Interface
- `XLEN`, 16: PC and register width.
- `BOFF_W`, 8: branch-offset field width in `ins`, sign-extended.
- `JIMM_W`, 11: page-absolute jump field width; must satisfy `BOFF_W <= JIMM_W < XLEN`.
- `RAS_DEPTH`, 4: return-stack entries, at least 2, power of two.
- `RESET_VEC`, 0: PC value after reset.
- `TRAP_VEC`, 16'h0004: trap handler address.

- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_en` in 1: commit `next_pc` into `pc` this cycle.
- `ins` in JIMM_W: immediate field of the current instruction.
- `branch` in 1: branch taken.
- `jump` in 2: 0 = sequential/branch, 1 = page-absolute, 2 = `rm`, 3 = `rd`.
- `call` in 1: push `pc_plus1` on commit.
- `ret` in 1: target is the popped RAS top.
- `trap` in 1: target is `TRAP_VEC` and `epc` is captured.
- `rm`, `rd` in XLEN: register operands.
- `pc` out XLEN: registered PC.
- `pc_plus1` out XLEN: `pc + 1`, combinational.
- `next_pc` out XLEN: selected target, combinational.
- `epc` out XLEN: PC of the last trapped instruction.
- `ras_empty`, `ras_full` out 1: RAS status, registered.
- `ras_uflow` out 1: one-cycle pulse after a `ret` commit with an empty RAS.

## Operation
- Target priority: `trap` > `ret` > `jump` != 0 > `branch` > sequential.
  - Sequential target: `pc + 1`.
  - Branch target: `pc + sext(ins[BOFF_W-1:0])`.
  - `jump` = 1 target: `{pc[XLEN-1:JIMM_W], ins}`.
  - `jump` = 2 target: `rm`. `jump` = 3 target: `rd`.
- All arithmetic is modulo 2^XLEN: `pc` = all-ones plus 1 gives 0. Negative offsets wrap the same way.
- `ret` with a non-empty RAS: the target is the top entry.
- `ret` with an empty RAS: the target falls back to `rm`, the pointer is unchanged, and `ras_uflow` pulses.
- `call` pushes `pc_plus1`; the target still comes from `jump`/`branch`.
- Full RAS on `call`: the push overwrites the oldest entry (circular), the count stays at `RAS_DEPTH`, and `ras_full` stays 1.
- `call` and `ret` in the same commit: the target is the old top. The top is then replaced by `pc_plus1` and the count is unchanged. On an empty RAS this is a plain push plus a `ras_uflow` pulse.
- `trap`: `epc <= pc`. The RAS is untouched, and `call`/`ret` are ignored in the same cycle.
- With `pc_en` = 0 there are no state changes. `next_pc` still tracks its inputs.

## Timing
- Reset values: `pc` = `RESET_VEC`, `epc` = 0, RAS count 0, `ras_empty` = 1, `ras_full` = 0, `ras_uflow` = 0. RAS entry contents are don't-care.
- `rst` overrides `pc_en` in the same cycle. A reset between commits discards all RAS contents.
- Commit latency: `next_pc` is visible on `pc` one cycle after the `pc_en` edge.
- `pc_plus1` and `next_pc` are purely combinational from `pc`, the RAS top and the inputs. There is no path from `pc_en` to `next_pc`.
- `ras_empty`/`ras_full` update on the same edge as the push or pop.
- `ras_uflow` is high for exactly the cycle after the offending commit.

## Structure
- Shared package holds the `jump` encoding constants (`JMP_SEQ`, `JMP_PAGE`, `JMP_RM`, `JMP_RD`) and the default `RESET_VEC`/`TRAP_VEC`.
- One sub-module, `pc_ras`. It is a circular LIFO parametrised by `XLEN`/`RAS_DEPTH`, with push, pop and replace, `top`, empty/full and an underflow pulse.
- Target muxing, the adders, `pc` and `epc` stay in `pc_sequencer`.

## Test plan
- Reset, then 3 commits with no control inputs -> `pc` = 0, 1, 2, 3; `ras_empty` = 1.
- `pc` = 16'h0010, `branch`, `ins[7:0]` = 8'hFC -> `pc` = 16'h000C.
- `pc` = 16'hFFFF, sequential commit -> `pc` = 0.
- `pc` = 16'h0812, `jump` = 1, `ins` = 11'h123 -> `pc` = 16'h0923.
- `jump` = 2 with `rm` = 16'h0ABC -> `pc` = 16'h0ABC.
- Calls at `pc` = 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) -> `ras_full`. Four `ret` commits give 0x51, 0x41, 0x31, 0x21. A fifth `ret` with `rm` = 0x77 gives `pc` = 0x77 and a one-cycle `ras_uflow`.
- With `trap` + `ret` + `call` together at `pc` = 0x30 -> `pc` = `TRAP_VEC`, `epc` = 0x30, RAS count unchanged.
- With `rst` asserted together with `pc_en` -> `pc` = `RESET_VEC`.
